// File: rtl/kavach_integrity_checker_if.sv
// rtl/kavach_integrity_checker_if.sv - memory read port between the integrity checker and protected memory
interface kavach_integrity_checker_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [31:0]           mem_rd_data;
  logic                  mem_rd_valid;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    input  mem_rd_valid
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    output mem_rd_valid
  );
endinterface

// File: rtl/kavach_integrity_checker.sv
// rtl/kavach_integrity_checker.sv - memory signature integrity checker; optional KAVACH_INTEG_STICKY_FAIL_EN
module kavach_integrity_checker #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           NUM_WORDS  = 32'd64,
  parameter logic [31:0]           SIG_SEED   = 32'hFFFFFFFF,
  parameter logic [31:0]           RD_TIMEOUT = 32'd64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              integ_check_req,
  input  logic [31:0]                       golden_sig,
  kavach_integrity_checker_if.master        mem,
  output logic                              integ_check_done,
  output logic                              integ_check_pass,
  output logic                              check_busy,
  output logic                              check_timeout,
  output logic [31:0]                       last_sig
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                state_q;
  logic                  req_q;
  logic [31:0]           sig_q;
  logic [31:0]           golden_q;
  logic [31:0]           word_cnt_q;
  logic [31:0]           tmo_cnt_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  done_q;
  logic                  pass_q;
  logic                  busy_q;
  logic                  tmo_q;
  logic [31:0]           last_sig_q;

  logic                  start_edge;
  logic                  in_check;
  logic                  abort;
  logic [31:0]           sig_next;
  logic [31:0]           word_cnt_inc;
  logic                  last_word;
  logic                  tmo_hit;
  logic                  sig_match;
  logic                  sticky_fail;

  // Only a fresh rising edge starts a check; a level still held after done does not.
  assign start_edge   = integ_check_req & ~req_q;
  assign in_check     = (state_q == S_START) || (state_q == S_ISSUE) ||
                        (state_q == S_WAIT)  || (state_q == S_COMPARE);
  assign abort        = in_check & ~integ_check_req;
  assign sig_next     = ({sig_q[30:0], sig_q[31]} ^ mem.mem_rd_data) + 32'h9E3779B9;
  assign word_cnt_inc = word_cnt_q + 32'd1;
  assign last_word    = (word_cnt_inc == NUM_WORDS);
  assign tmo_hit      = (tmo_cnt_q + 32'd1) >= RD_TIMEOUT;
  assign sig_match    = (sig_q == golden_q);

`ifdef KAVACH_INTEG_STICKY_FAIL_EN
  logic sticky_q;
  logic fail_evt;

  // A failure counts only when the check actually completes (not on an abort cycle).
  assign fail_evt = ~abort & (((state_q == S_COMPARE) & ~sig_match) |
                              ((state_q == S_WAIT) & ~mem.mem_rd_valid & tmo_hit));

  // Sticky failure flag: once any check fails, later passes are suppressed until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (fail_evt) begin
      sticky_q <= 1'b1;
    end
  end

  assign sticky_fail = sticky_q;
`else
  assign sticky_fail = 1'b0;
`endif

  // Check sequencer: walks the region one outstanding read at a time, all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      sig_q      <= '0;
      golden_q   <= '0;
      word_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= BASE_ADDR;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      last_sig_q <= '0;
    end else begin
      req_q   <= integ_check_req;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort) begin
        // Requester withdrew: drop silently, any late read response falls on IDLE.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_edge) begin
              state_q    <= S_START;
              sig_q      <= SIG_SEED;
              word_cnt_q <= '0;
              golden_q   <= golden_sig;
              pass_q     <= 1'b0;
              tmo_q      <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
          S_START: begin
            state_q   <= S_ISSUE;
            rd_en_q   <= 1'b1;
            rd_addr_q <= BASE_ADDR + word_cnt_q[ADDR_WIDTH-1:0];
          end
          S_ISSUE: begin
            state_q   <= S_WAIT;
            tmo_cnt_q <= '0;
          end
          S_WAIT: begin
            if (mem.mem_rd_valid) begin
              // Valid wins over a coinciding timeout.
              sig_q      <= sig_next;
              word_cnt_q <= word_cnt_inc;
              if (last_word) begin
                state_q <= S_COMPARE;
              end else begin
                state_q   <= S_ISSUE;
                rd_en_q   <= 1'b1;
                rd_addr_q <= BASE_ADDR + word_cnt_inc[ADDR_WIDTH-1:0];
              end
            end else if (tmo_hit) begin
              state_q <= S_DONE;
              tmo_q   <= 1'b1;
              pass_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 32'd1;
            end
          end
          S_COMPARE: begin
            state_q    <= S_DONE;
            pass_q     <= sig_match & ~sticky_fail;
            last_sig_q <= sig_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem.mem_rd_en     = rd_en_q;
  assign mem.mem_rd_addr   = rd_addr_q;
  assign integ_check_done  = done_q;
  assign integ_check_pass  = pass_q;
  assign check_busy        = busy_q;
  assign check_timeout     = tmo_q;
  assign last_sig          = last_sig_q;

endmodule
